// File: rtl/pwm_pkg.sv
// Shared state encoding and default constants for the PWM duty generator.
package pwm_pkg;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } pwm_state_t;

    localparam int PWM_PERIOD          = 100;
    localparam int PWM_STEP            = 10;
    localparam int PWM_DUTY_INIT       = 50;
    localparam int PWM_DUTY_W          = 7;
    localparam int PWM_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/switch_edge_detect.sv
// Two-flop synchroniser, optional debounce filter (DEBOUNCE_EN) and single-cycle
// rising-edge pulse for one switch level.
module switch_edge_detect
    import pwm_pkg::*;
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = PWM_DEBOUNCE_CYCLES
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    // NOTE: non-blocking assignments so each flop samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_level;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_db_cnt;
    logic             r_filt;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
        end else if (r_sync2 != r_filt) begin
            if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_filt   <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/pwm_duty_generator.sv
// Switch-driven PWM generator: saturating duty register, run/stop FSM and period
// counter with duty updates applied at period boundaries. Optional macro: DEBOUNCE_EN.
module pwm_duty_generator
    import pwm_pkg::*;
#(
    parameter int PERIOD    = PWM_PERIOD,
    parameter int STEP      = PWM_STEP,
    parameter int DUTY_INIT = PWM_DUTY_INIT,
    parameter int DUTY_W    = PWM_DUTY_W
`ifdef DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = PWM_DEBOUNCE_CYCLES
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swt_increase,
    input  logic              swt_decrease,
    input  logic              swt_start_stop,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty,
    output logic              running
);

    localparam logic [DUTY_W:0]   LP_PERIOD_X = (DUTY_W + 1)'(PERIOD);
    localparam logic [DUTY_W:0]   LP_STEP_X   = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] LP_PERIOD   = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] LP_LAST     = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] LP_INIT     = DUTY_W'(DUTY_INIT);

    logic [2:0] w_sw;
    logic [2:0] w_rise;
    logic       w_inc;
    logic       w_dec;
    logic       w_ss;

    assign w_sw = {swt_start_stop, swt_decrease, swt_increase};

    for (genvar g = 0; g < 3; g++) begin : g_sw
`ifdef DEBOUNCE_EN
        switch_edge_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_edge (
            .clk     (clk),
            .rst     (rst),
            .i_level (w_sw[g]),
            .o_rise  (w_rise[g])
        );
`else
        switch_edge_detect u_edge (
            .clk     (clk),
            .rst     (rst),
            .i_level (w_sw[g]),
            .o_rise  (w_rise[g])
        );
`endif
    end

    assign w_inc = w_rise[0];
    assign w_dec = w_rise[1];
    assign w_ss  = w_rise[2];

    pwm_state_t        r_state;
    pwm_state_t        w_state_next;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_next;
    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] w_cnt_next;
    logic [DUTY_W-1:0] r_duty_act;
    logic [DUTY_W-1:0] w_duty_act_next;
    logic              r_pwm;
    logic              w_pwm_next;
    logic [DUTY_W:0]   w_ext;
    logic [DUTY_W:0]   w_sum;
    logic [DUTY_W:0]   w_diff;

    // One extra bit so the saturation compares cannot be fooled by wrap-around.
    assign w_ext  = {1'b0, r_duty};
    assign w_sum  = w_ext + LP_STEP_X;
    assign w_diff = w_ext - LP_STEP_X;

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        w_duty_next = r_duty;
        if (w_inc && !w_dec) begin
            w_duty_next = (w_sum > LP_PERIOD_X) ? LP_PERIOD : w_sum[DUTY_W-1:0];
        end else if (w_dec && !w_inc) begin
            w_duty_next = (w_ext < LP_STEP_X) ? '0 : w_diff[DUTY_W-1:0];
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = '0;
        w_duty_act_next = r_duty_act;
        w_pwm_next      = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                if (w_ss) begin
                    w_state_next    = ST_RUN;
                    w_duty_act_next = w_duty_next;
                    w_pwm_next      = (w_duty_next != '0);
                end
            end
            ST_RUN: begin
                if (w_ss) begin
                    w_state_next = ST_STOPPED;
                end else begin
                    if (r_cnt == LP_LAST) begin
                        w_duty_act_next = w_duty_next;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                    w_pwm_next = (w_cnt_next < w_duty_act_next);
                end
            end
            default: w_state_next = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_STOPPED;
            r_duty     <= LP_INIT;
            r_cnt      <= '0;
            r_duty_act <= LP_INIT;
            r_pwm      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_duty     <= w_duty_next;
            r_cnt      <= w_cnt_next;
            r_duty_act <= w_duty_act_next;
            r_pwm      <= w_pwm_next;
        end
    end

    assign pwm_out = r_pwm;
    assign duty    = r_duty;
    assign running = (r_state == ST_RUN);

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Directed self-checking bench for pwm_duty_generator (defaults PERIOD=100, STEP=10,
// DUTY_INIT=50). Build with DEBOUNCE_EN to add the glitch-rejection step.
module tb_pwm_duty_generator;

`ifdef DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif
    // Edges from input change to visible update; pulse width; settle gap between pulses.
    localparam int LAT = 3 + DB;
    localparam int PW  = (DB == 0) ? 1 : DB + 2;
    localparam int GAP = PW + DB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       ss  = 1'b0;
    logic       pwm;
    logic [6:0] duty;
    logic       running;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef DEBOUNCE_EN
    pwm_duty_generator #(.DEBOUNCE_CYCLES(DB)) dut (
`else
    pwm_duty_generator dut (
`endif
        .clk            (clk),
        .rst            (rst),
        .swt_increase   (inc),
        .swt_decrease   (dec),
        .swt_start_stop (ss),
        .pwm_out        (pwm),
        .duty           (duty),
        .running        (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c, input int n);
        inc = a;
        dec = b;
        ss  = c;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i + 1 == PW) begin
                inc = 1'b0;
                dec = 1'b0;
                ss  = 1'b0;
            end
        end
        inc = 1'b0;
        dec = 1'b0;
        ss  = 1'b0;
    endtask

    task automatic pulse_chk(input logic a, input logic b, input string tag, input int exp_duty);
        drive(a, b, 1'b0, LAT);
        check(tag, 32'(duty), exp_duty);
        repeat (GAP) tick();
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm === 1'b1) hi++;
            tick();
        end
    endtask

    // Leaves the bench on the first sample of a period (pwm low -> high transition).
    task automatic wait_period_start(output logic ok);
        logic seen_low  = 1'b0;
        logic seen_high = 1'b0;
        for (int i = 0; i < 250 && !seen_low; i++) begin
            if (pwm === 1'b0) seen_low = 1'b1;
            else tick();
        end
        for (int i = 0; i < 250 && seen_low && !seen_high; i++) begin
            if (pwm === 1'b1) seen_high = 1'b1;
            else tick();
        end
        ok = seen_low & seen_high;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   hi;
        int   exp_d;
        logic ok;

        // Reset with swt_increase already high: release yields exactly one event.
        inc = 1'b1;
        repeat (2) tick();
        check("rst_duty", 32'(duty), 50);
        check("rst_running", 32'(running), 0);
        check("rst_pwm", 32'(pwm), 0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, LAT);
        check("release_event", 32'(duty), 60);
        repeat (GAP) tick();
        pulse_chk(1'b0, 1'b1, "dec_to_50", 50);

        // Start: running one edge late, not earlier; 50 high per period.
        drive(1'b0, 1'b0, 1'b1, LAT - 1);
        check("start_before_lat", 32'(running), 0);
        tick();
        check("start_running", 32'(running), 1);
        check("start_pwm", 32'(pwm), 1);
        for (int p = 0; p < 3; p++) begin
            count_high(100, hi);
            check("high_50", 32'(hi), 50);
        end

        // Held level is one event only.
        inc = 1'b1;
        repeat (500) tick();
        inc = 1'b0;
        check("hold_once", 32'(duty), 60);
        repeat (GAP) tick();
        pulse_chk(1'b1, 1'b0, "inc_70", 70);
        pulse_chk(1'b1, 1'b0, "inc_80", 80);
        pulse_chk(1'b1, 1'b0, "inc_90", 90);
        pulse_chk(1'b1, 1'b0, "inc_100", 100);
        pulse_chk(1'b1, 1'b0, "inc_sat", 100);
        repeat (100) tick();
        count_high(100, hi);
        check("high_full", 32'(hi), 100);

        exp_d = 100;
        for (int k = 0; k < 11; k++) begin
            exp_d = (exp_d < 10) ? 0 : exp_d - 10;
            pulse_chk(1'b0, 1'b1, "dec_step", exp_d);
        end
        check("dec_floor", 32'(duty), 0);
        repeat (100) tick();
        count_high(100, hi);
        check("high_zero", 32'(hi), 0);

        // Mid-period increase at cnt=20 only affects the following period.
        for (int k = 0; k < 5; k++) pulse_chk(1'b1, 1'b0, "inc_back", (k + 1) * 10);
        wait_period_start(ok);
        check("period_start_found", 32'(ok), 1);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (pwm === 1'b1) hi++;
            if (i == 20 - LAT) inc = 1'b1;
            if (i == 20 - LAT + PW) inc = 1'b0;
            if (i == 20) check("mid_inc_duty", 32'(duty), 60);
            tick();
        end
        check("mid_cur_period", 32'(hi), 50);
        count_high(100, hi);
        check("mid_next_period", 32'(hi), 60);

        // Simultaneous inc/dec cancels; stop then restart.
        pulse_chk(1'b0, 1'b1, "dec_50_again", 50);
        pulse_chk(1'b1, 1'b1, "inc_dec_same", 50);
        drive(1'b0, 1'b0, 1'b1, LAT - 1);
        check("stop_before_lat", 32'(running), 1);
        tick();
        check("stop_running", 32'(running), 0);
        check("stop_pwm", 32'(pwm), 0);
        repeat (GAP) tick();
        count_high(100, hi);
        check("stopped_low", 32'(hi), 0);
        drive(1'b0, 1'b0, 1'b1, LAT);
        check("restart_running", 32'(running), 1);
        check("restart_pwm", 32'(pwm), 1);
        count_high(100, hi);
        check("restart_cnt0", 32'(hi), 50);

`ifdef DEBOUNCE_EN
        inc = 1'b1;
        repeat (5) tick();
        inc = 1'b0;
        repeat (30) tick();
        check("glitch_reject", 32'(duty), 50);
`endif

        // Asynchronous reset between edges at cnt=30.
        pulse_chk(1'b1, 1'b0, "inc_pre_rst", 60);
        wait_period_start(ok);
        check("period_start_found2", 32'(ok), 1);
        repeat (30) tick();
        check("pre_rst_pwm", 32'(pwm), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_pwm", 32'(pwm), 0);
        check("async_running", 32'(running), 0);
        check("async_duty", 32'(duty), 50);
        repeat (2) tick();
        rst = 1'b0;
        repeat (LAT + 2) tick();
        check("post_rst_running", 32'(running), 0);
        check("post_rst_duty", 32'(duty), 50);
        check("post_rst_pwm", 32'(pwm), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_duty_generator.md
Name: pwm_duty_generator

Overview:
Downstream consumer of the switch controller outputs (swt_increase, swt_decrease, swt_start_stop). Converts switch level changes into duty-cycle adjustments and run/stop commands, and generates the PWM waveform that drives the board output. Synchronises and edge-detects each switch, holds a saturating duty register, and runs a period counter with glitch-free duty update at period boundaries.

Parameters:
PERIOD, 100, PWM period in clk cycles; must be at least 2.
STEP, 10, duty change per increase/decrease event, in clk cycles.
DUTY_INIT, 50, duty value after reset; must satisfy 0 <= DUTY_INIT <= PERIOD.
DUTY_W, 7, width of the duty and counter registers; 2^DUTY_W must be greater than PERIOD.
DEBOUNCE_CYCLES, 1000, stable-cycle count required per input; used only when DEBOUNCE_EN is defined.

Ports:
clk  in  1  system clock; all flops on the rising edge.
rst  in  1  asynchronous, active-high reset.
swt_increase  in  1  switch level from controller; a rising edge raises duty.
swt_decrease  in  1  switch level from controller; a rising edge lowers duty.
swt_start_stop  in  1  switch level from controller; a rising edge toggles run/stop.
pwm_out  out  1  registered PWM output.
duty  out  DUTY_W  current commanded duty value.
running  out  1  high while the FSM is in ST_RUN.

Behaviour:
- Reset (async, immediate): duty=DUTY_INIT; FSM=ST_STOPPED; running=0; cnt=0; duty_active=DUTY_INIT; pwm_out=0; all sync, prev and debounce flops cleared to 0.
- A switch already high at reset release therefore produces one rising-edge event. This is intentional.
- Input path per switch: 2-flop synchroniser, then a prev register. rise = sync2 & ~prev.
- Event latency: input high before clk edge 1 -> the state/duty update is visible after edge 3.
- A level held high generates exactly one event. Falling edges are ignored.
- Duty arithmetic in DUTY_W+1 bits:
  - inc: duty = min(duty+STEP, PERIOD).
  - dec: duty = (duty < STEP) ? 0 : duty-STEP.
  - inc and dec rise in the same cycle: duty unchanged.
- Duty adjustments are accepted in both FSM states.
- FSM states: ST_STOPPED, ST_RUN.
  - ST_STOPPED -> ST_RUN on a start_stop rise. On that edge, cnt=0 and duty_active loads the current duty (post-update if inc/dec fire in the same cycle).
  - ST_RUN -> ST_STOPPED on a start_stop rise. On that edge, cnt=0 and pwm_out=0.
- Counter: in ST_RUN, cnt increments by 1 each cycle and wraps from PERIOD-1 to 0. When it wraps, duty_active loads duty. In ST_STOPPED, cnt is held at 0.
- pwm_out (registered): in ST_RUN, next pwm_out = (cnt_next < duty_active_next); in ST_STOPPED, 0.
  - duty=0 gives constant low.
  - duty=PERIOD gives constant high.
  - High time per period equals duty_active.
- A duty change mid-period does not affect the current period. It takes effect from the next period start.
- running is the registered FSM state.

Optional Feature:
DEBOUNCE_EN
- Defined: after the synchroniser, each input passes through a debounce counter. The filtered level changes only after the sync2 value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap resets the counter. Edge detect runs on the filtered level. Event latency grows by DEBOUNCE_CYCLES. The counter resets to 0 and the filtered level to 0.
- Undefined: no debounce logic is present; latency is as stated above.

Decomposition:
- Package pwm_pkg: state typedef (ST_STOPPED, ST_RUN), default constants (PERIOD, STEP, DUTY_INIT, DUTY_W, DEBOUNCE_CYCLES).
- Sub-module switch_edge_detect: synchroniser, optional debounce and rise pulse; one instance per switch, three in total.
- Duty register, FSM, counter and output logic live in pwm_duty_generator.

Test Plan:
All scenarios use defaults PERIOD=100, STEP=10, DUTY_INIT=50.
1. Reset, then pulse swt_start_stop high -> running=1 after edge 3; pwm_out high for exactly 50 of every 100 cycles over 3 periods.
2. Hold swt_increase high 500 cycles -> duty 60 only. Then 5 more separate pulses -> duty saturates at 100, and pwm_out is constant 1 from the next period start.
3. From 50, 6 swt_decrease pulses -> duty 0 with no underflow wrap; pwm_out is constant 0 from the next period.
4. While running, at cnt=20 pulse swt_increase -> duty=60 immediately; the current period has 50 high cycles and the next has 60.
5. swt_increase and swt_decrease rising on the same cycle -> duty stays 50. A second start_stop pulse while running -> running=0 and pwm_out=0 after edge 3, with cnt held at 0.
6. Assert rst asynchronously mid-period at cnt=30, between clock edges -> pwm_out=0, running=0, duty=50 without waiting for a clk edge. With DEBOUNCE_EN, DEBOUNCE_CYCLES=8 and a 5-cycle glitch on swt_increase -> no duty change.
